mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory stage of the 16-bit pipelined CPU, between the EX/MEM register and the MEM/WB register. Loads and stores go to an internal synchronous data RAM with a configurable multi-cycle latency; every other instruction passes through in the same cycle. While an access is in flight the stage stalls upstream and drives a bubble into MEM/WB. Its outputs connect straight to the MEM/WB inputs of the same name.

## Interface
- ADDR_W, 8, word-address bits; RAM depth 2^ADDR_W × 16
- MEM_LAT, 2, cycles a memory op occupies the stage; legal 2..8
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EX/MEM holds a valid instruction
- alu_result_in  in  16  ALU result; byte address for memory ops
- store_data_in  in  16  store data
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- rd_in  in  3  destination register
- mem_to_reg_in  in  1  WB mux select
- reg_write_in  in  1  register-file write enable
- funct_in  in  3  function code
- stall  out  1  hold EX/MEM and earlier stages this cycle
- alu_result_out  out  16  to MEM/WB
- mem_data_out  out  16  load data to MEM/WB
- rd_out  out  3  to MEM/WB
- mem_to_reg_out  out  1  to MEM/WB
- reg_write_out  out  1  to MEM/WB
- funct_out  out  3  to MEM/WB

## Operation
- Word address is alu_result_in[ADDR_W:1]. Bit 0 is ignored except in byte mode.
- A memory op is in_valid & (mem_read_in | mem_write_in). If both are high, the op is a load and the write is suppressed.
- Non-memory valid op: outputs are combinational copies of the inputs, mem_data_out = 0, stall = 0.
- Bubble: all outputs 0, including reg_write_out and mem_to_reg_out. A bubble is driven when in_valid = 0, during stall cycles, and while rst is high.
- FSM states: IDLE, WAIT, DONE.
  - IDLE + memory op:
    - Capture address, store data and control into holding registers.
    - Issue a RAM read of the word.
    - stall = 1; drive bubble.
    - Next state is WAIT if MEM_LAT > 2, else DONE.
  - WAIT: stall = 1; bubble. A down-counter loaded with MEM_LAT-2 decrements each cycle; move to DONE when it reaches 1.
  - DONE:
    - stall = 0.
    - Outputs come from the holding registers; mem_data_out = registered read word (0 for stores).
    - A store writes the RAM on this cycle's clock edge.
    - Next state is IDLE.
- A back-to-back memory op is accepted in the cycle after DONE, so a load issued after a store always sees the stored data.
- RAM contents are not cleared by rst. In simulation they initialise to 0.

## Timing
- Non-memory op: 0-cycle latency, combinational path.
- Memory op: stall high for exactly MEM_LAT-1 cycles, then result presented for 1 cycle. EX/MEM must hold its inputs stable while stall = 1.
- Reset values: state = IDLE, counter = 0, holding registers = 0, stall = 0, all outputs 0.
- rst during WAIT or DONE:
  - Next cycle is IDLE with stall = 0.
  - A pending store is discarded and the RAM is unmodified.
  - A pending load result is lost.
- stall depends only on state and counter, plus in_valid and mem_read_in/mem_write_in while in IDLE. It never depends on RAM data.

## Configuration
- DMEM_BYTE_ACCESS_EN defined: funct_in = 3'b100 on a memory op selects byte mode. alu_result_in[0] selects the byte (0 = [7:0], 1 = [15:8]).
  - Byte load returns the selected byte zero-extended.
  - Byte store merges store_data_in[7:0] into the word read at accept and writes the merged word in DONE.
- DMEM_BYTE_ACCESS_EN undefined: funct_in has no effect on memory; every access is a full word.

## Test plan
- Reset: rst high 2 cycles mid-traffic → stall = 0, all outputs 0, state IDLE.
- Pass-through: in_valid = 1, alu_result_in = 0x1234, rd_in = 3, reg_write_in = 1, no memory op → same cycle: alu_result_out = 0x1234, rd_out = 3, reg_write_out = 1, stall = 0.
- MEM_LAT = 2: store 0xBEEF to 0x0010, then load 0x0010 with rd = 5.
  - Each op: stall = 1 for 1 cycle with reg_write_out = 0.
  - Load DONE cycle: mem_data_out = 0xBEEF, rd_out = 5.
- MEM_LAT = 4 load → stall high for exactly 3 consecutive cycles, then data for 1 cycle; a non-memory op behind it passes in the next cycle.
- Reset mid-op: 0x0020 holds 0x1111; start a store of 0x2222 there and assert rst in WAIT → a subsequent load of 0x0020 returns 0x1111.
- Byte mode, 0x0010 holding 0xBEEF:
  - Macro on: byte store 0x55 to 0x0011 → word reads 0x55EF; byte load 0x0010 → 0x00EF.
  - Macro off, same funct: full-word behaviour.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory stage with multi-cycle synchronous data RAM
//
// Purpose: sits between EX/MEM and MEM/WB. Non-memory instructions pass straight
// through combinationally; loads/stores occupy the stage for MEM_LAT cycles, during
// which upstream is stalled and a bubble is driven into MEM/WB.
//
// Optional feature macro: DMEM_BYTE_ACCESS_EN (funct_in == 3'b100 selects byte access).
//
// Parameters: ADDR_W (word-address bits), MEM_LAT (cycles per memory op, 2..8)
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid                      EX/MEM holds a valid instruction
//   alu_result_in[15:0]           ALU result / byte address for memory ops
//   store_data_in[15:0]           store data
//   mem_read_in, mem_write_in     load / store request
//   rd_in[2:0], mem_to_reg_in, reg_write_in, funct_in[2:0]   control carried to WB
//   stall                         hold EX/MEM and earlier stages
//   alu_result_out, mem_data_out, rd_out, mem_to_reg_out, reg_write_out, funct_out
//                                 MEM/WB register inputs

module mem_access_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] alu_result_in,
  input  logic [15:0] store_data_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  rd_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic [2:0]  funct_in,
  output logic        stall,
  output logic [15:0] alu_result_out,
  output logic [15:0] mem_data_out,
  output logic [2:0]  rd_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic [2:0]  funct_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 2);

  state_t state, state_nxt;
  logic [2:0] cnt;

  logic [15:0] ram [0:(1 << ADDR_W) - 1];

  // Holding registers for the instruction in flight
  logic [15:0] h_alu;
  logic [15:0] h_wdata;
  logic [15:0] rd_word;
  logic        h_read;
  logic        h_write;
  logic        h_byte;
  logic [2:0]  h_rd;
  logic        h_mem_to_reg;
  logic        h_reg_write;
  logic [2:0]  h_funct;

  logic        mem_op;
  logic        byte_in;
  logic [15:0] load_word;
  logic [15:0] store_word;

  assign mem_op = in_valid & (mem_read_in | mem_write_in);

`ifdef DMEM_BYTE_ACCESS_EN
  assign byte_in = (funct_in == 3'b100);
`else
  assign byte_in = 1'b0;
`endif

  // Byte lanes: alu bit 0 picks the upper (1) or lower (0) byte of the word
  always_comb begin
    load_word  = rd_word;
    store_word = h_wdata;
    if (h_byte) begin
      load_word  = h_alu[0] ? {8'h00, rd_word[15:8]} : {8'h00, rd_word[7:0]};
      store_word = h_alu[0] ? {h_wdata[7:0], rd_word[7:0]}
                            : {rd_word[15:8], h_wdata[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      h_alu        <= 16'h0000;
      h_wdata      <= 16'h0000;
      rd_word      <= 16'h0000;
      h_read       <= 1'b0;
      h_write      <= 1'b0;
      h_byte       <= 1'b0;
      h_rd         <= 3'd0;
      h_mem_to_reg <= 1'b0;
      h_reg_write  <= 1'b0;
      h_funct      <= 3'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (mem_op) begin
            h_alu        <= alu_result_in;
            h_wdata      <= store_data_in;
            h_read       <= mem_read_in;
            // a simultaneous read+write is treated as a load only
            h_write      <= mem_write_in & ~mem_read_in;
            h_byte       <= byte_in;
            h_rd         <= rd_in;
            h_mem_to_reg <= mem_to_reg_in;
            h_reg_write  <= reg_write_in;
            h_funct      <= funct_in;
            cnt          <= CNT_INIT;
            // read issued for stores too: byte stores merge into this word
            rd_word      <= ram[alu_result_in[ADDR_W:1]];
          end
        end
        WAIT:    cnt <= cnt - 3'd1;
        default: ;
      endcase
    end
  end

  // Stores commit on the DONE edge only; a reset arriving earlier discards them
  always_ff @(posedge clk) begin
    if (!rst && state == DONE && h_write) begin
      ram[h_alu[ADDR_W:1]] <= store_word;
    end
  end

  always_comb begin
    state_nxt      = state;
    stall          = 1'b0;
    alu_result_out = 16'h0000;
    mem_data_out   = 16'h0000;
    rd_out         = 3'd0;
    mem_to_reg_out = 1'b0;
    reg_write_out  = 1'b0;
    funct_out      = 3'd0;

    case (state)
      IDLE: begin
        if (mem_op) begin
          state_nxt = (MEM_LAT > 2) ? WAIT : DONE;
          stall     = 1'b1;
        end else if (in_valid) begin
          alu_result_out = alu_result_in;
          rd_out         = rd_in;
          mem_to_reg_out = mem_to_reg_in;
          reg_write_out  = reg_write_in;
          funct_out      = funct_in;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt <= 3'd1) state_nxt = DONE;
      end
      DONE: begin
        state_nxt      = IDLE;
        alu_result_out = h_alu;
        mem_data_out   = h_read ? load_word : 16'h0000;
        rd_out         = h_rd;
        mem_to_reg_out = h_mem_to_reg;
        reg_write_out  = h_reg_write;
        funct_out      = h_funct;
      end
      default: state_nxt = IDLE;
    endcase

    // reset forces a bubble with no stall
    if (rst) begin
      stall          = 1'b0;
      alu_result_out = 16'h0000;
      mem_data_out   = 16'h0000;
      rd_out         = 3'd0;
      mem_to_reg_out = 1'b0;
      reg_write_out  = 1'b0;
      funct_out      = 3'd0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage (MEM_LAT 2 and 4)

module tb_mem_access_stage;

  localparam int LAT0 = 2;
  localparam int LAT1 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [2];
  logic [15:0] alu_in   [2];
  logic [15:0] sd_in    [2];
  logic        mr_in    [2];
  logic        mw_in    [2];
  logic [2:0]  rd_in    [2];
  logic        m2r_in   [2];
  logic        rw_in    [2];
  logic [2:0]  fn_in    [2];
  logic        stall    [2];
  logic [15:0] alu_out  [2];
  logic [15:0] md_out   [2];
  logic [2:0]  rd_out   [2];
  logic        m2r_out  [2];
  logic        rw_out   [2];
  logic [2:0]  fn_out   [2];

  int tests = 0;
  int fails = 0;

  logic [15:0] ref_mem [2][256];

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(8), .MEM_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .alu_result_in(alu_in[0]),
    .store_data_in(sd_in[0]), .mem_read_in(mr_in[0]), .mem_write_in(mw_in[0]),
    .rd_in(rd_in[0]), .mem_to_reg_in(m2r_in[0]), .reg_write_in(rw_in[0]),
    .funct_in(fn_in[0]), .stall(stall[0]), .alu_result_out(alu_out[0]),
    .mem_data_out(md_out[0]), .rd_out(rd_out[0]), .mem_to_reg_out(m2r_out[0]),
    .reg_write_out(rw_out[0]), .funct_out(fn_out[0])
  );

  mem_access_stage #(.ADDR_W(8), .MEM_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .alu_result_in(alu_in[1]),
    .store_data_in(sd_in[1]), .mem_read_in(mr_in[1]), .mem_write_in(mw_in[1]),
    .rd_in(rd_in[1]), .mem_to_reg_in(m2r_in[1]), .reg_write_in(rw_in[1]),
    .funct_in(fn_in[1]), .stall(stall[1]), .alu_result_out(alu_out[1]),
    .mem_data_out(md_out[1]), .rd_out(rd_out[1]), .mem_to_reg_out(m2r_out[1]),
    .reg_write_out(rw_out[1]), .funct_out(fn_out[1])
  );

  function automatic int lat_of(int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(string tag, int d, logic [15:0] obs, logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic idle_inputs(int d);
    in_valid[d] = 1'b0; alu_in[d] = 16'h0; sd_in[d] = 16'h0;
    mr_in[d] = 1'b0; mw_in[d] = 1'b0; rd_in[d] = 3'd0;
    m2r_in[d] = 1'b0; rw_in[d] = 1'b0; fn_in[d] = 3'd0;
  endtask

  task automatic chk_bubble(string tag, int d, logic exp_stall);
    chk({tag, "_stall"}, d, 16'(stall[d]), 16'(exp_stall));
    chk({tag, "_alu"}, d, alu_out[d], 16'h0);
    chk({tag, "_md"}, d, md_out[d], 16'h0);
    chk({tag, "_ctl"}, d, {8'h0, rd_out[d], fn_out[d], m2r_out[d], rw_out[d]}, 16'h0);
  endtask

  // Non-memory instruction (or in_valid=0 bubble): result visible in the same cycle
  task automatic pass_op(int d, logic vld, logic [15:0] a, logic [2:0] rdst,
                         logic rw, logic m2r, logic [2:0] fn, logic mr, logic mw);
    in_valid[d] = vld; alu_in[d] = a; sd_in[d] = 16'($urandom);
    mr_in[d] = mr; mw_in[d] = mw; rd_in[d] = rdst;
    m2r_in[d] = m2r; rw_in[d] = rw; fn_in[d] = fn;
    @(negedge clk);
    if (vld) begin
      chk("pass_stall", d, 16'(stall[d]), 16'h0);
      chk("pass_alu", d, alu_out[d], a);
      chk("pass_md", d, md_out[d], 16'h0);
      chk("pass_ctl", d, {8'h0, rd_out[d], fn_out[d], m2r_out[d], rw_out[d]},
          {8'h0, rdst, fn, m2r, rw});
    end else begin
      chk_bubble("invalid", d, 1'b0);
    end
    @(posedge clk); #1;
    idle_inputs(d);
  endtask

  // Memory instruction; expectations come from the word-array model
  task automatic mem_op(int d, logic r, logic w, logic [15:0] a, logic [15:0] data,
                        logic [2:0] rdst, logic [2:0] fn, logic m2r, logic rw);
    logic [15:0] word;
    logic [15:0] exp_md;
    logic [7:0]  wa;
    logic        bytem;
    wa = a[8:1];
    bytem = 1'b0;
`ifdef DMEM_BYTE_ACCESS_EN
    bytem = (fn == 3'b100);
`endif
    word = ref_mem[d][wa];
    exp_md = 16'h0;
    if (r) begin
      if (bytem) exp_md = a[0] ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
      else       exp_md = word;
    end else if (w) begin
      if (bytem) ref_mem[d][wa] = a[0] ? {data[7:0], word[7:0]} : {word[15:8], data[7:0]};
      else       ref_mem[d][wa] = data;
    end
    in_valid[d] = 1'b1; alu_in[d] = a; sd_in[d] = data;
    mr_in[d] = r; mw_in[d] = w; rd_in[d] = rdst;
    m2r_in[d] = m2r; rw_in[d] = rw; fn_in[d] = fn;
    for (int k = 0; k < lat_of(d) - 1; k++) begin
      @(negedge clk);
      chk_bubble("memwait", d, 1'b1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("done_stall", d, 16'(stall[d]), 16'h0);
    chk("done_alu", d, alu_out[d], a);
    chk("done_md", d, md_out[d], exp_md);
    chk("done_ctl", d, {8'h0, rd_out[d], fn_out[d], m2r_out[d], rw_out[d]},
        {8'h0, rdst, fn, m2r, rw});
    @(posedge clk); #1;
    idle_inputs(d);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom);
    a[8:5] = 4'h0;
    return a;
  endfunction

  initial begin
    logic [15:0] v;
    int kind;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) ref_mem[d][i] = 16'h0;
    end

    // Reset held two cycles with a valid instruction present: bubble, no stall
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      idle_inputs(d);
      in_valid[d] = 1'b1; alu_in[d] = 16'h5A5A; rw_in[d] = 1'b1; mr_in[d] = 1'b1;
    end
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk_bubble("reset", d, 1'b0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int d = 0; d < 2; d++) idle_inputs(d);

    for (int d = 0; d < 2; d++) begin
      // preload the word addresses used by random traffic
      for (int w = 0; w < 16; w++)
        mem_op(d, 1'b0, 1'b1, 16'(w * 2), 16'($urandom), 3'd0, 3'd0, 1'b0, 1'b0);

      pass_op(d, 1'b1, 16'h1234, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      pass_op(d, 1'b0, 16'h4321, 3'd6, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);

      // store then back-to-back load, then a non-memory op right behind it
      mem_op(d, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 3'd1, 3'd0, 1'b0, 1'b0);
      mem_op(d, 1'b1, 1'b0, 16'h0010, 16'h0000, 3'd5, 3'd0, 1'b1, 1'b1);
      pass_op(d, 1'b1, 16'h00A5, 3'd2, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);

      // reset while a store is in flight must leave memory untouched
      mem_op(d, 1'b0, 1'b1, 16'h0020, 16'h1111, 3'd0, 3'd0, 1'b0, 1'b0);
      in_valid[d] = 1'b1; alu_in[d] = 16'h0020; sd_in[d] = 16'h2222; mw_in[d] = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) begin
        @(negedge clk);
        chk_bubble("midrst", d, 1'b0);
        @(posedge clk); #1;
      end
      rst = 1'b0;
      idle_inputs(d);
      pass_op(d, 1'b1, 16'h0F0F, 3'd4, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0);
      mem_op(d, 1'b1, 1'b0, 16'h0020, 16'h0000, 3'd7, 3'd0, 1'b1, 1'b1);

      // byte-mode funct code on word 0x0010 holding 0xBEEF
      mem_op(d, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 3'd0, 3'd0, 1'b0, 1'b0);
      mem_op(d, 1'b0, 1'b1, 16'h0011, 16'hA755, 3'd0, 3'b100, 1'b0, 1'b0);
      mem_op(d, 1'b1, 1'b0, 16'h0010, 16'h0000, 3'd2, 3'd0, 1'b1, 1'b1);
      mem_op(d, 1'b1, 1'b0, 16'h0010, 16'h0000, 3'd3, 3'b100, 1'b1, 1'b1);
      mem_op(d, 1'b1, 1'b1, 16'h0011, 16'h9999, 3'd4, 3'b100, 1'b1, 1'b1);
      mem_op(d, 1'b1, 1'b0, 16'h0011, 16'h0000, 3'd6, 3'd0, 1'b1, 1'b1);
    end

    // randomized traffic, alternating between the two latencies
    for (int i = 0; i < 120; i++) begin
      int d;
      d = i % 2;
      kind = $urandom_range(0, 4);
      v = 16'($urandom);
      case (kind)
        0: pass_op(d, 1'b1, v, 3'($urandom), 1'($urandom), 1'($urandom),
                   3'($urandom), 1'b0, 1'b0);
        1: pass_op(d, 1'b0, v, 3'($urandom), 1'($urandom), 1'($urandom),
                   3'($urandom), 1'($urandom), 1'($urandom));
        2: mem_op(d, 1'b1, 1'($urandom), rand_addr(), v, 3'($urandom),
                  ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom), 1'($urandom), 1'($urandom));
        default: mem_op(d, 1'b0, 1'b1, rand_addr(), v, 3'($urandom),
                        ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom), 1'($urandom), 1'($urandom));
      endcase
    end

    // read back every preloaded word as a final memory-image check
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++)
        mem_op(d, 1'b1, 1'b0, 16'(w * 2), 16'h0, 3'd1, 3'd0, 1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
